// File: rtl/jk_sync_counter.sv
// Modulo-MODULUS up/down counter built from per-bit JK stages with
// minimal excitation, synchronous range-checked load and wrap/load-error pulses.
module jk_sync_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic [WIDTH-1:0] j_o,
  output logic [WIDTH-1:0] k_o,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_V = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] q_q, q_d, nxt;
  logic             wrap_q, wrap_d;
  logic             load_err_q, load_err_d;
  logic             load_ok, at_top, at_bot;

  always_comb begin
    load_ok = ({1'b0, load_val} < MOD_V);
    at_top  = (q_q == MAX_V);
    at_bot  = (q_q == '0);

    nxt = q_q;
    if (load) begin
      if (load_ok) nxt = load_val;
    end else if (en) begin
      if (up) nxt = at_top ? '0 : q_q + 1'b1;
      else    nxt = at_bot ? MAX_V : q_q - 1'b1;
    end

    // Excitation derived from the target so J and K are never both set.
    j_o = nxt & ~q_q;
    k_o = ~nxt & q_q;
    q_d = (j_o & ~q_q) | (~k_o & q_q);

    tc         = en & ~load & (up ? at_top : at_bot);
    wrap_d     = tc;
    load_err_d = load & ~load_ok;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q        <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign q        = q_q;
  assign qn       = ~q_q;
  assign wrap     = wrap_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_jk_sync_counter.sv
// Scoreboard bench for jk_sync_counter: directed scenarios plus random
// stimulus checked against an arithmetic modulo-counter model.
module tb_jk_sync_counter;
  localparam int W = 4;
  localparam int M = 10;

  logic clk = 1'b0;
  logic rst, en, up, load;
  logic [W-1:0] load_val;
  logic [W-1:0] q, qn, j_o, k_o;
  logic tc, wrap, load_err;

  jk_sync_counter #(.WIDTH(W), .MODULUS(M)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .q(q), .qn(qn), .j_o(j_o), .k_o(k_o), .tc(tc), .wrap(wrap), .load_err(load_err)
  );

  always #5 clk = ~clk;

  typedef struct { int tc; int j; int k; int qn; } comb_t;
  typedef struct { int q; int wrap; int err; } st_t;

  comb_t comb_q[$];
  st_t   st_q[$];
  int total = 0;
  int bad   = 0;

  int mq = 0, mwrap = 0, merr = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One driver slot: inputs change 2 time units after the rising edge.
  task automatic step(input logic r, input logic e, input logic u,
                      input logic l, input int lv);
    int n, t, jj, kk;
    comb_t c;
    st_t   s;
    @(posedge clk);
    #2;
    rst = r; en = e; up = u; load = l; load_val = W'(lv);
    if (r) begin
      mq = 0; mwrap = 0; merr = 0;
      #1;
      chk("rst_q", int'(q), 0);
      chk("rst_qn", int'(qn), (1 << W) - 1);
      chk("rst_wrap", int'(wrap), 0);
      chk("rst_err", int'(load_err), 0);
    end
    if (l) n = (lv < M) ? lv : mq;
    else if (e) n = u ? (mq + 1) % M : (mq + M - 1) % M;
    else n = mq;
    t  = (e && !l && (u ? (mq + 1 == M) : (mq == 0))) ? 1 : 0;
    jj = n & ~mq & ((1 << W) - 1);
    kk = ~n & mq & ((1 << W) - 1);
    c.tc = t; c.j = jj; c.k = kk; c.qn = ~mq & ((1 << W) - 1);
    comb_q.push_back(c);
    if (r) begin
      mq = 0; mwrap = 0; merr = 0;
    end else begin
      mwrap = t;
      merr  = (l && lv >= M) ? 1 : 0;
      mq    = n;
    end
    s.q = mq; s.wrap = mwrap; s.err = merr;
    st_q.push_back(s);
  endtask

  initial begin : monitor
    comb_t c;
    st_t   s;
    forever begin
      @(negedge clk);
      if (comb_q.size() > 0) begin
        c = comb_q.pop_front();
        chk("tc", int'(tc), c.tc);
        chk("j_o", int'(j_o), c.j);
        chk("k_o", int'(k_o), c.k);
        chk("qn", int'(qn), c.qn);
        chk("jk_overlap", int'(j_o & k_o), 0);
      end
      @(posedge clk);
      #1;
      if (st_q.size() > 0) begin
        s = st_q.pop_front();
        chk("q", int'(q), s.q);
        chk("wrap", int'(wrap), s.wrap);
        chk("load_err", int'(load_err), s.err);
        chk("q_in_range", (int'(q) < M) ? 1 : 0, 1);
      end
    end
  end

  initial begin
    int drain;
    rst = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; load_val = '0;
    #3;
    chk("por_q", int'(q), 0);
    chk("por_qn", int'(qn), (1 << W) - 1);
    step(1, 0, 0, 0, 0);
    // count up 12 edges from reset: 1..9,0,1,2
    for (int i = 0; i < 12; i++) step(0, 1, 1, 0, 0);
    // down from 0 wraps to 9, then 8
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    // load beats count; out-of-range load holds and flags
    step(0, 0, 0, 1, 3);
    step(0, 1, 0, 1, 7);
    step(0, 1, 1, 1, 12);
    step(0, 0, 0, 0, 0);
    // hold
    step(0, 0, 0, 1, 5);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
    // async reset mid-count, then resume from 0
    step(0, 0, 0, 1, 6);
    step(0, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    // reset while a wrap and a load error are pending
    step(0, 0, 0, 1, 9);
    step(0, 1, 1, 0, 0);
    step(1, 0, 0, 1, 15);
    // random
    for (int i = 0; i < 3000; i++) begin
      int r = $urandom_range(0, 99);
      step((r == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
           1'($urandom),
           ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
           int'($urandom_range(0, (1 << W) - 1)));
    end
    @(posedge clk);
    #2;
    en = 1'b0; load = 1'b0; rst = 1'b0;
    drain = 0;
    while ((comb_q.size() > 0 || st_q.size() > 0) && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    #3;
    chk("scoreboard_drained", comb_q.size() + st_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
